// File: rtl/debouncer_2ch.sv
// debouncer_2ch: two independent debounce channels. Each channel commits a new
// output level only after STABLE_CYCLES consecutive enabled samples of that level.
// Optional build macro DEBOUNCE_SYNC_EN adds a 2-flop synchronizer per channel
// in front of the FSM. The synchronizer runs every cycle and adds two cycles
// of latency.
module debouncer_2ch #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] in_raw,
    output logic [1:0] out_stable,
    output logic [1:0] pending
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    // Count value on which the STABLE_CYCLES-th matching sample commits
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_meta;
    logic [1:0] sync_out;

    // Two-flop synchronizer per channel, free-running so en never stalls it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 2'b00;
            sync_out  <= 2'b00;
        end else begin
            sync_meta <= in_raw;
            sync_out  <= sync_meta;
        end
    end

    assign s = sync_out;
`else
    assign s = in_raw;
`endif

    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t               state;
        state_t               state_nxt;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nxt;
        logic                 out_q;
        logic                 out_nxt;
        logic                 pend_q;

        // State, counter, debounced level and pending flag registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= STABLE_LOW;
                cnt    <= CNT_ZERO;
                out_q  <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                out_q  <= out_nxt;
                pend_q <= (state_nxt == CHECK_HIGH) || (state_nxt == CHECK_LOW);
            end
        end

        // Next-state logic: a mismatching sample opens a check, a full run commits,
        // any sample back at the committed level abandons the check
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            out_nxt   = out_q;
            if (en) begin
                case (state)
                    STABLE_LOW: begin
                        if (s[i]) begin
                            state_nxt = CHECK_HIGH;
                            cnt_nxt   = CNT_ONE;
                        end else begin
                            cnt_nxt   = CNT_ZERO;
                        end
                    end
                    CHECK_HIGH: begin
                        if (s[i]) begin
                            if (cnt >= CNT_LAST) begin
                                state_nxt = STABLE_HIGH;
                                cnt_nxt   = CNT_ZERO;
                                out_nxt   = 1'b1;
                            end else begin
                                cnt_nxt   = cnt + CNT_ONE;
                            end
                        end else begin
                            state_nxt = STABLE_LOW;
                            cnt_nxt   = CNT_ZERO;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!s[i]) begin
                            state_nxt = CHECK_LOW;
                            cnt_nxt   = CNT_ONE;
                        end else begin
                            cnt_nxt   = CNT_ZERO;
                        end
                    end
                    CHECK_LOW: begin
                        if (!s[i]) begin
                            if (cnt >= CNT_LAST) begin
                                state_nxt = STABLE_LOW;
                                cnt_nxt   = CNT_ZERO;
                                out_nxt   = 1'b0;
                            end else begin
                                cnt_nxt   = cnt + CNT_ONE;
                            end
                        end else begin
                            state_nxt = STABLE_HIGH;
                            cnt_nxt   = CNT_ZERO;
                        end
                    end
                    default: begin
                        state_nxt = STABLE_LOW;
                        cnt_nxt   = CNT_ZERO;
                        out_nxt   = 1'b0;
                    end
                endcase
            end
        end

        assign out_stable[i] = out_q;
        assign pending[i]    = pend_q;
    end

endmodule

// File: tb/tb_debouncer_2ch.sv
// tb_debouncer_2ch: randomized and directed stimulus for debouncer_2ch, checked
// every cycle against a run-length model of the debounce rule.
module tb_debouncer_2ch;

    localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] in_raw;
    logic [1:0] out_stable;
    logic [1:0] pending;

    int checks;
    int errors;

    // Reference model: committed level, length of the current run of samples
    // differing from it, and the input history standing in for the synchronizer
    int   lvl  [2];
    int   run  [2];
    logic hist [2][2];

    debouncer_2ch #(.STABLE_CYCLES(N), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_raw     (in_raw),
        .out_stable (out_stable),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] expOut();
        return {lvl[1] != 0, lvl[0] != 0};
    endfunction

    function automatic logic [1:0] expPend();
        return {run[1] > 0, run[0] > 0};
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            lvl[c]     = 0;
            run[c]     = 0;
            hist[c][0] = 1'b0;
            hist[c][1] = 1'b0;
        end
    endtask

    task automatic modelEdge(input logic [1:0] raw, input logic e);
        for (int c = 0; c < 2; c++) begin
            int smp;
            if (SYNC_LAT == 2) begin
                smp        = int'(hist[c][1]);
                hist[c][1] = hist[c][0];
                hist[c][0] = raw[c];
            end else begin
                smp = int'(raw[c]);
            end
            if (e) begin
                if (smp != lvl[c]) begin
                    run[c]++;
                    if (run[c] == N) begin
                        lvl[c] = smp;
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
    endtask

    // One clock edge with the given inputs, then compare against the model
    task automatic applyStimulus(input logic [1:0] raw, input logic e);
        in_raw = raw;
        en     = e;
        @(posedge clk);
        modelEdge(raw, e);
        #1;
        checkOutput("out_stable", int'(out_stable), int'(expOut()));
        checkOutput("pending", int'(pending), int'(expPend()));
    endtask

    task automatic doReset();
        in_raw = 2'b00;
        en     = 1'b1;
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_out", int'(out_stable), 0);
        checkOutput("reset_pend", int'(pending), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rise;
        logic [1:0] r;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        en     = 1'b1;
        in_raw = 2'b00;
        modelReset();
        doReset();

        // Idle after reset: no activity
        for (int k = 0; k < 6; k++) applyStimulus(2'b00, 1'b1);

        // Commit latency: ch1 steady high, ch0 bouncing every cycle
        rise = -1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus({1'b1, k[0]}, 1'b1);
            if (out_stable[1] && rise < 0) rise = k;
        end
        checkOutput("rise_edge_ch1", rise, N - 1 + SYNC_LAT);
        checkOutput("bounce_ch0", int'(out_stable[0]), 0);

        // Single-channel latency from reset, ch0
        doReset();
        rise = -1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(2'b01, 1'b1);
            if (out_stable[0] && rise < 0) rise = k;
        end
        checkOutput("rise_edge_ch0", rise, N - 1 + SYNC_LAT);

        // Glitch inside a run: 1,1,1,0,1,1,1,1 on ch1
        doReset();
        begin
            logic [7:0] pat;
            pat = 8'b1111_0111;
            for (int k = 0; k < 8; k++) applyStimulus({pat[k], 1'b0}, 1'b1);
            for (int k = 0; k < 4; k++) applyStimulus(2'b10, 1'b1);
        end

        // en=0 freezes an open run
        doReset();
        applyStimulus(2'b01, 1'b1);
        applyStimulus(2'b01, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(2'b01, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(2'b01, 1'b1);

        // Async reset in the middle of CHECK_LOW discards the partial count
        doReset();
        for (int k = 0; k < N + SYNC_LAT + 2; k++) applyStimulus(2'b11, 1'b1);
        for (int k = 0; k < SYNC_LAT + 2; k++) applyStimulus(2'b00, 1'b1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst_out", int'(out_stable), 0);
        checkOutput("async_rst_pend", int'(pending), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N + SYNC_LAT + 2; k++) applyStimulus(2'b11, 1'b1);

        // Randomized slow-bouncing inputs with occasional enable gaps
        doReset();
        r = 2'b00;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) r[0] = ~r[0];
            if ($urandom_range(5) == 0) r[1] = ~r[1];
            applyStimulus(r, ($urandom_range(9) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
